// File: rtl/zphoton_counter_array_if.sv
// Result handoff between the photon counter and the display sequencer.
// The counter side drives the latched result; the display side returns ack.
interface zphoton_counter_array_if #(
   parameter int CHANNELS  = 4,
   parameter int CNT_WIDTH = 32
);
   logic                          valid;
   logic                          ack;
   logic                          overrun;
   logic [CHANNELS*CNT_WIDTH-1:0] counts;
   logic [CHANNELS-1:0]           overflow;

   modport master (
      output valid,
      output overrun,
      output counts,
      output overflow,
      input  ack
   );

   modport slave (
      input  valid,
      input  overrun,
      input  counts,
      input  overflow,
      output ack
   );
endinterface

// File: rtl/zphoton_counter_array.sv
// Multi-channel gated photon counter with built-in test-pulse generator.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | no gate open; waits for start (single-shot) or mode=1
//   GATING | gate window open; live counters accumulate detected edges
//
// The live overflow bit is set when an edge arrives while the live counter
// already holds its maximum value; the count itself never wraps.
module zphoton_counter_array #(
   parameter int CHANNELS    = 4,
   parameter int CNT_WIDTH   = 32,
   parameter int GATE_CYCLES = 20_000_000,
   parameter int TEST_PERIOD = 20_000_000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [CHANNELS-1:0]   ex_pulse,
   input  logic                  test_sel,
   input  logic                  mode,
   input  logic                  start,
   output logic                  test_pulse,
   output logic                  busy,
   zphoton_counter_array_if.master res
);

   localparam int TPW = (TEST_PERIOD > 1) ? $clog2(TEST_PERIOD) : 1;
   localparam int GW  = $clog2(GATE_CYCLES);
   localparam logic [TPW-1:0]       TP_LAST   = TPW'(TEST_PERIOD - 1);
   localparam logic [GW-1:0]        GATE_LAST = GW'(GATE_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};

   typedef enum logic {IDLE, GATING} state_t;

   state_t                        state;
   logic [TPW-1:0]                tp_cnt;
   logic [GW-1:0]                 gate_cnt;
   logic [CHANNELS-1:0]           sync1, sync2, prev, sel, rise;
   logic [CNT_WIDTH-1:0]          live    [CHANNELS];
   logic [CNT_WIDTH-1:0]          live_nx [CHANNELS];
   logic [CHANNELS-1:0]           live_ovf, live_ovf_nx;
   logic [CHANNELS*CNT_WIDTH-1:0] live_flat;
   logic                          valid_q, overrun_q;
   logic [CHANNELS*CNT_WIDTH-1:0] counts_q;
   logic [CHANNELS-1:0]           overflow_q;

   assign res.valid    = valid_q;
   assign res.overrun  = overrun_q;
   assign res.counts   = counts_q;
   assign res.overflow = overflow_q;

   // Free-running test generator; pulse is registered on the terminal count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tp_cnt     <= '0;
         test_pulse <= 1'b0;
      end else begin
         test_pulse <= (tp_cnt == TP_LAST);
         tp_cnt     <= (tp_cnt == TP_LAST) ? '0 : tp_cnt + TPW'(1);
      end
   end

   // Two-flop synchroniser on the external pins plus the edge-detect history.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
         prev  <= '0;
      end else begin
         sync1 <= ex_pulse;
         sync2 <= sync1;
         prev  <= sel;
      end
   end

   assign sel  = test_sel ? {CHANNELS{test_pulse}} : sync2;
   assign rise = sel & ~prev;

   // Post-increment view of the live counters, used both for counting and latching.
   always_comb begin
      live_ovf_nx = live_ovf;
      live_flat   = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         live_nx[k] = live[k];
         if (rise[k]) begin
            if (live[k] == CNT_MAX) live_ovf_nx[k] = 1'b1;
            else                    live_nx[k]     = live[k] + CNT_WIDTH'(1);
         end
         live_flat[k*CNT_WIDTH +: CNT_WIDTH] = live_nx[k];
      end
   end

   // Gate sequencing, live counting, result latch and valid/ack handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         busy       <= 1'b0;
         gate_cnt   <= '0;
         live_ovf   <= '0;
         valid_q    <= 1'b0;
         overrun_q  <= 1'b0;
         counts_q   <= '0;
         overflow_q <= '0;
         for (int k = 0; k < CHANNELS; k++) live[k] <= '0;
      end else begin
         // An accepted ack retires the result; a coincident gate end below
         // re-raises valid for the fresh result.
         if (valid_q && res.ack) begin
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (mode || start) begin
                  state    <= GATING;
                  busy     <= 1'b1;
                  gate_cnt <= '0;
                  live_ovf <= '0;
                  for (int k = 0; k < CHANNELS; k++) live[k] <= '0;
               end
            end
            GATING: begin
               if (gate_cnt == GATE_LAST) begin
                  counts_q   <= live_flat;
                  overflow_q <= live_ovf_nx;
                  valid_q    <= 1'b1;
                  if (valid_q && !res.ack) overrun_q <= 1'b1;
                  gate_cnt   <= '0;
                  live_ovf   <= '0;
                  for (int k = 0; k < CHANNELS; k++) live[k] <= '0;
                  if (!mode) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  gate_cnt <= gate_cnt + GW'(1);
                  live_ovf <= live_ovf_nx;
                  for (int k = 0; k < CHANNELS; k++) live[k] <= live_nx[k];
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_zphoton_counter_array.sv
// Bench for zphoton_counter_array: a short-gate instance (100 cycles) and a
// long-gate instance (2000 cycles) for the pulse-train and saturation cases.
module tb_zphoton_counter_array;

   localparam int CH = 4;
   localparam int CW = 8;

   typedef struct {
      logic [31:0] counts;
      logic [3:0]  ovf;
      logic        ovr;
   } res_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_m, rst_l;
   logic [3:0] ex_m, ex_l;
   logic       test_sel_m, mode_m, start_m, test_sel_l, mode_l, start_l;
   logic       tp_m, busy_m, tp_l, busy_l;
   logic       mon_ack_m = 1'b0, stim_ack_m = 1'b0, mon_ack_l = 1'b0;
   bit         ack_en_m = 1'b0, ack_en_l = 1'b0;
   int         checks = 0, failures = 0;
   res_t       q_m[$], q_l[$];

   zphoton_counter_array_if #(.CHANNELS(CH), .CNT_WIDTH(CW)) bus_m ();
   zphoton_counter_array_if #(.CHANNELS(CH), .CNT_WIDTH(CW)) bus_l ();

   assign bus_m.ack = mon_ack_m | stim_ack_m;
   assign bus_l.ack = mon_ack_l;

   zphoton_counter_array #(.CHANNELS(CH), .CNT_WIDTH(CW), .GATE_CYCLES(100), .TEST_PERIOD(10)) dut (
      .clk(clk), .rst(rst_m), .ex_pulse(ex_m), .test_sel(test_sel_m), .mode(mode_m),
      .start(start_m), .test_pulse(tp_m), .busy(busy_m), .res(bus_m));

   zphoton_counter_array #(.CHANNELS(CH), .CNT_WIDTH(CW), .GATE_CYCLES(2000), .TEST_PERIOD(10)) dut_l (
      .clk(clk), .rst(rst_l), .ex_pulse(ex_l), .test_sel(test_sel_l), .mode(mode_l),
      .start(start_l), .test_pulse(tp_l), .busy(busy_l), .res(bus_l));

   function automatic res_t mk(input logic [31:0] c, input logic [3:0] o, input logic r);
      res_t t;
      t.counts = c;
      t.ovf    = o;
      t.ovr    = r;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Pulse a channel n times (3 high / 3 low); first rising edge is driven at
   // the negedge just before posedge a, counting posedge 1 as the start sample.
   task automatic pulses(input bit lng, input int ch, input int a, input int n);
      repeat (a - 1) @(negedge clk);
      for (int i = 0; i < n; i++) begin
         if (lng) ex_l[ch] = 1'b1; else ex_m[ch] = 1'b1;
         repeat (3) @(negedge clk);
         if (lng) ex_l[ch] = 1'b0; else ex_m[ch] = 1'b0;
         repeat (3) @(negedge clk);
      end
   endtask

   task automatic wait_q(input bit lng, input int maxc, input string name);
      int n = 0;
      while ((lng ? q_l.size() : q_m.size()) != 0 && n < maxc) begin
         @(negedge clk);
         n++;
      end
      chk(name, 32'(lng ? q_l.size() : q_m.size()), 32'd0);
      repeat (3) @(negedge clk);
   endtask

   // Display-side monitor for the short-gate instance.
   initial begin : mon_m
      res_t e;
      forever begin
         @(negedge clk);
         if (bus_m.valid === 1'b1 && ack_en_m && q_m.size() > 0) begin
            e = q_m.pop_front();
            chk("m_counts", bus_m.counts, e.counts);
            chk("m_overflow", 32'(bus_m.overflow), 32'(e.ovf));
            chk("m_overrun", 32'(bus_m.overrun), 32'(e.ovr));
            mon_ack_m = 1'b1;
            @(negedge clk);
            mon_ack_m = 1'b0;
            chk("m_valid_clear", 32'(bus_m.valid), 32'd0);
            chk("m_overrun_clear", 32'(bus_m.overrun), 32'd0);
         end
      end
   end

   // Display-side monitor for the long-gate instance.
   initial begin : mon_l
      res_t e;
      forever begin
         @(negedge clk);
         if (bus_l.valid === 1'b1 && ack_en_l && q_l.size() > 0) begin
            e = q_l.pop_front();
            chk("l_counts", bus_l.counts, e.counts);
            chk("l_overflow", 32'(bus_l.overflow), 32'(e.ovf));
            chk("l_overrun", 32'(bus_l.overrun), 32'(e.ovr));
            mon_ack_l = 1'b1;
            @(negedge clk);
            mon_ack_l = 1'b0;
            chk("l_valid_clear", 32'(bus_l.valid), 32'd0);
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "time limit");
   end

   initial begin : stim
      int bcnt, vcnt, last, np, prevtp;
      int per [2];
      rst_m = 1'b1; rst_l = 1'b1;
      ex_m = '0; ex_l = '0;
      test_sel_m = 1'b0; mode_m = 1'b0; start_m = 1'b0;
      test_sel_l = 1'b0; mode_l = 1'b0; start_l = 1'b0;
      repeat (3) @(negedge clk);

      chk("rst_counts", bus_m.counts, 32'd0);
      chk("rst_overflow", 32'(bus_m.overflow), 32'd0);
      chk("rst_valid", 32'(bus_m.valid), 32'd0);
      chk("rst_overrun", 32'(bus_m.overrun), 32'd0);
      chk("rst_busy", 32'(busy_m), 32'd0);
      chk("rst_test_pulse", 32'(tp_m), 32'd0);
      chk("rst_l_busy", 32'(busy_l), 32'd0);
      chk("rst_l_test_pulse", 32'(tp_l), 32'd0);
      rst_m = 1'b0; rst_l = 1'b0;

      // Single-shot gate on the test pulse, with start retriggers mid-gate.
      test_sel_m = 1'b1; ack_en_m = 1'b1;
      repeat (5) @(negedge clk);
      q_m.push_back(mk(32'h0a0a0a0a, 4'h0, 1'b0));
      start_m = 1'b1;
      bcnt = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         start_m = (i == 20 || i == 40);
         if (busy_m) bcnt++;
      end
      chk("busy_len", 32'(bcnt), 32'd100);
      wait_q(1'b0, 50, "m_drain_single");

      // ack while nothing is valid has no effect.
      stim_ack_m = 1'b1;
      @(negedge clk);
      stim_ack_m = 1'b0;
      @(negedge clk);
      chk("ack_idle_valid", 32'(bus_m.valid), 32'd0);
      chk("ack_idle_overrun", 32'(bus_m.overrun), 32'd0);

      // Continuous mode, three windows, never acked.
      test_sel_m = 1'b0; ack_en_m = 1'b0; mode_m = 1'b1;
      fork
         pulses(1'b0, 0, 10, 2);
         pulses(1'b0, 1, 110, 3);
         pulses(1'b0, 0, 210, 4);
         pulses(1'b0, 3, 230, 1);
         begin repeat (249) @(negedge clk); mode_m = 1'b0; end
      join
      repeat (60) @(negedge clk);
      chk("cont_busy_off", 32'(busy_m), 32'd0);
      q_m.push_back(mk(32'h01000004, 4'h0, 1'b1));
      ack_en_m = 1'b1;
      wait_q(1'b0, 50, "m_drain_overrun");

      // Continuous mode with ack coinciding with the second gate end.
      ack_en_m = 1'b0; mode_m = 1'b1;
      fork
         pulses(1'b0, 1, 10, 2);
         pulses(1'b0, 2, 110, 3);
         begin
            repeat (200) @(negedge clk);
            chk("coinc_valid_before", 32'(bus_m.valid), 32'd1);
            chk("coinc_counts_before", bus_m.counts, 32'h00000200);
            stim_ack_m = 1'b1;
            @(negedge clk);
            stim_ack_m = 1'b0;
            chk("coinc_valid", 32'(bus_m.valid), 32'd1);
            chk("coinc_overrun", 32'(bus_m.overrun), 32'd0);
            chk("coinc_counts", bus_m.counts, 32'h00030000);
         end
         begin repeat (249) @(negedge clk); mode_m = 1'b0; end
      join
      repeat (60) @(negedge clk);
      q_m.push_back(mk(32'h00000000, 4'h0, 1'b1));
      ack_en_m = 1'b1;
      wait_q(1'b0, 50, "m_drain_coinc");

      // Asynchronous reset in the middle of a gate.
      ack_en_m = 1'b0; test_sel_m = 1'b1; mode_m = 1'b0;
      start_m = 1'b1;
      @(negedge clk);
      start_m = 1'b0;
      repeat (150) @(negedge clk);
      chk("pre_rst_valid", 32'(bus_m.valid), 32'd1);
      chk("pre_rst_counts", bus_m.counts, 32'h0a0a0a0a);
      start_m = 1'b1;
      @(negedge clk);
      start_m = 1'b0;
      repeat (48) @(negedge clk);
      chk("pre_rst_busy", 32'(busy_m), 32'd1);
      #2 rst_m = 1'b1;
      #1;
      chk("arst_counts", bus_m.counts, 32'd0);
      chk("arst_overflow", 32'(bus_m.overflow), 32'd0);
      chk("arst_valid", 32'(bus_m.valid), 32'd0);
      chk("arst_overrun", 32'(bus_m.overrun), 32'd0);
      chk("arst_busy", 32'(busy_m), 32'd0);
      chk("arst_test_pulse", 32'(tp_m), 32'd0);
      @(negedge clk);
      rst_m = 1'b0;
      vcnt = 0;
      for (int i = 0; i < 150; i++) begin
         @(negedge clk);
         if (bus_m.valid || busy_m) vcnt++;
      end
      chk("post_rst_quiet", 32'(vcnt), 32'd0);
      per[0] = 0; per[1] = 0; np = 0; last = -1; prevtp = 0;
      for (int i = 0; i < 60 && np < 2; i++) begin
         @(negedge clk);
         if (tp_m && prevtp == 0) begin
            if (last >= 0) begin
               per[np] = i - last;
               np++;
            end
            last = i;
         end
         prevtp = int'(tp_m);
      end
      chk("tp_period0", 32'(per[0]), 32'd10);
      chk("tp_period1", 32'(per[1]), 32'd10);

      // Long gate: mixed pulse trains with last-cycle / one-after boundary edges.
      ack_en_l = 1'b1;
      q_l.push_back(mk(32'h01250005, 4'h0, 1'b0));
      start_l = 1'b1;
      fork
         begin @(negedge clk); start_l = 1'b0; end
         pulses(1'b1, 0, 10, 5);
         pulses(1'b1, 2, 10, 37);
         pulses(1'b1, 3, 1999, 1);
         pulses(1'b1, 1, 2000, 1);
      join
      wait_q(1'b1, 100, "l_drain_trains");

      // Long gate: saturation on channel 2.
      q_l.push_back(mk(32'h00ff0000, 4'b0100, 1'b0));
      start_l = 1'b1;
      fork
         begin @(negedge clk); start_l = 1'b0; end
         pulses(1'b1, 2, 5, 300);
      join
      wait_q(1'b1, 400, "l_drain_sat");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
